// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit: bypass select
// encoding, shadow stage record and stage indices.
package fwd_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_EXE = 2'b11
    } fwd_sel_e;

    // rd is held at a fixed maximum width and zero-extended from REG_AW
    localparam int RD_W = 8;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            is_load;
    } stage_t;

    localparam int STG_EXE = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
    localparam int NUM_STG = 3;

    function automatic fwd_sel_e stage_sel(input int idx);
        case (idx)
            STG_EXE: stage_sel = FWD_EXE;
            STG_MEM: stage_sel = FWD_MEM;
            STG_WB:  stage_sel = FWD_WB;
            default: stage_sel = FWD_RF;
        endcase
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand source match against the EXE/MEM/WB shadow stages; returns
// the youngest winning bypass and whether that winner is a not-yet-ready load.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_used,
    input  logic              i_id_valid,
    input  stage_t            i_exe,
    input  stage_t            i_mem,
    input  stage_t            i_wb,
    output fwd_sel_e          o_sel,
    output logic              o_not_ready
);

    stage_t              w_stg [NUM_STG];
    logic [NUM_STG-1:0]  w_hit;
    logic                w_found;

    assign w_stg[STG_EXE] = i_exe;
    assign w_stg[STG_MEM] = i_mem;
    assign w_stg[STG_WB]  = i_wb;

    // rd == 0 is excluded, so an x0 source can never match any stage
    always_comb begin
        for (int s = 0; s < NUM_STG; s++) begin
            w_hit[s] = w_stg[s].valid & w_stg[s].we & (w_stg[s].rd != '0) &
                       (w_stg[s].rd == RD_W'(i_rs)) & i_used & i_id_valid;
        end
    end

    always_comb begin
        o_sel       = FWD_RF;
        o_not_ready = 1'b0;
        w_found     = 1'b0;
        for (int s = 0; s < NUM_STG; s++) begin
            if (!w_found && w_hit[s]) begin
                w_found = 1'b1;
                if (w_stg[s].is_load && (s < LOAD_LAT)) begin
                    o_not_ready = 1'b1;
                end else begin
                    o_sel = stage_sel(s);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller with its own EXE/MEM/WB shadow
// pipeline. Optional stall counter enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      PIPE_ADV,
    input  logic                      FLUSH,
    input  logic                      ID_VALID,
    input  logic [NUM_SRC*REG_AW-1:0] ID_RS_ADDR,
    input  logic [NUM_SRC-1:0]        ID_RS_USED,
    input  logic [REG_AW-1:0]         ID_RD_ADDR,
    input  logic                      ID_RD_WE,
    input  logic                      ID_IS_LOAD,
    output logic [NUM_SRC*2-1:0]      FWD_SEL,
    output logic                      STALL
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]               STALL_CNT
`endif
);

    stage_t             r_exe;
    stage_t             r_mem;
    stage_t             r_wb;
    stage_t             w_exe_nxt;
    fwd_sel_e           w_sel [NUM_SRC];
    logic [NUM_SRC-1:0] w_not_ready;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .REG_AW   (REG_AW),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .i_rs        (ID_RS_ADDR[i*REG_AW +: REG_AW]),
            .i_used      (ID_RS_USED[i]),
            .i_id_valid  (ID_VALID),
            .i_exe       (r_exe),
            .i_mem       (r_mem),
            .i_wb        (r_wb),
            .o_sel       (w_sel[i]),
            .o_not_ready (w_not_ready[i])
        );
        assign FWD_SEL[i*2 +: 2] = w_sel[i];
    end

    assign STALL = |w_not_ready;

    // A stalled or flushed ID instruction enters EXE as a bubble
    always_comb begin
        w_exe_nxt = '0;
        if (ID_VALID && !STALL && !FLUSH) begin
            w_exe_nxt.valid   = 1'b1;
            w_exe_nxt.rd      = RD_W'(ID_RD_ADDR);
            w_exe_nxt.we      = ID_RD_WE;
            w_exe_nxt.is_load = ID_IS_LOAD;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_exe <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (PIPE_ADV) begin
            r_wb  <= r_mem;
            r_mem <= r_exe;
            r_exe <= w_exe_nxt;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cnt <= '0;
        end else if (STALL && PIPE_ADV && !FLUSH && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one LOAD_LAT=1 and one LOAD_LAT=2
// instance driven by the same stimulus. Counter checks need FWD_PERF_CNT_EN.
module tb_fwd_hazard_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        PIPE_ADV;
    logic        FLUSH;
    logic        ID_VALID;
    logic [9:0]  ID_RS_ADDR;
    logic [1:0]  ID_RS_USED;
    logic [4:0]  ID_RD_ADDR;
    logic        ID_RD_WE;
    logic        ID_IS_LOAD;
    logic [3:0]  FWD_SEL;
    logic        STALL;
    logic [3:0]  FWD_SEL2;
    logic        STALL2;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] STALL_CNT;
    logic [31:0] STALL_CNT2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .PIPE_ADV   (PIPE_ADV),
        .FLUSH      (FLUSH),
        .ID_VALID   (ID_VALID),
        .ID_RS_ADDR (ID_RS_ADDR),
        .ID_RS_USED (ID_RS_USED),
        .ID_RD_ADDR (ID_RD_ADDR),
        .ID_RD_WE   (ID_RD_WE),
        .ID_IS_LOAD (ID_IS_LOAD),
        .FWD_SEL    (FWD_SEL),
        .STALL      (STALL)
`ifdef FWD_PERF_CNT_EN
        ,
        .STALL_CNT  (STALL_CNT)
`endif
    );

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2)) dut2 (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .PIPE_ADV   (PIPE_ADV),
        .FLUSH      (FLUSH),
        .ID_VALID   (ID_VALID),
        .ID_RS_ADDR (ID_RS_ADDR),
        .ID_RS_USED (ID_RS_USED),
        .ID_RD_ADDR (ID_RD_ADDR),
        .ID_RD_WE   (ID_RD_WE),
        .ID_IS_LOAD (ID_IS_LOAD),
        .FWD_SEL    (FWD_SEL2),
        .STALL      (STALL2)
`ifdef FWD_PERF_CNT_EN
        ,
        .STALL_CNT  (STALL_CNT2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [1:0] u, input logic [4:0] rd, input logic we,
                      input logic ld);
        ID_VALID   = v;
        ID_RS_ADDR = {r2, r1};
        ID_RS_USED = u;
        ID_RD_ADDR = rd;
        ID_RD_WE   = we;
        ID_IS_LOAD = ld;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N  = 1'b0;
        PIPE_ADV = 1'b1;
        FLUSH    = 1'b0;
        id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);

        // Reset state
        tick();
        @(negedge CLK);
        chk("reset_sel", {28'd0, FWD_SEL}, 32'h0);
        chk("reset_stall", {31'd0, STALL}, 32'h0);
`ifdef FWD_PERF_CNT_EN
        chk("reset_cnt", STALL_CNT, 32'h0);
`endif
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // add x5 then add x6,x5,x1 -> EXE bypass on rs1
        id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t1_first_sel", {28'd0, FWD_SEL}, 32'h0);
        tick();
        id(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t1_exe_sel", {28'd0, FWD_SEL}, 32'h3);
        chk("t1_exe_stall", {31'd0, STALL}, 32'h0);
        tick();

        // x5 two ahead -> MEM; next cycle x5 in WB and x6 in MEM
        id(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("t2_mem_sel", {28'd0, FWD_SEL}, 32'h2);
        tick();
        id(1'b1, 5'd5, 5'd6, 2'b11, 5'd5, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t2_wb_mem_sel", {28'd0, FWD_SEL}, 32'h9);
        tick();
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0);
        tick();
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
        tick();
        // EXE=x5, MEM=x9, WB=x5: youngest x5 wins on rs1, rs2 gets MEM
        id(1'b1, 5'd5, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("t2_youngest_sel", {28'd0, FWD_SEL}, 32'hB);
        tick();

        // Load-use, both latencies
        do_reset();
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        id(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t3_ll1_stall_c1", {31'd0, STALL}, 32'h1);
        chk("t3_ll1_sel_c1", {28'd0, FWD_SEL}, 32'h0);
        chk("t3_ll2_stall_c1", {31'd0, STALL2}, 32'h1);
        tick();
        @(negedge CLK);
        chk("t3_ll1_stall_c2", {31'd0, STALL}, 32'h0);
        chk("t3_ll1_sel_c2", {28'd0, FWD_SEL}, 32'hA);
        chk("t3_ll2_stall_c2", {31'd0, STALL2}, 32'h1);
        chk("t3_ll2_sel_c2", {28'd0, FWD_SEL2}, 32'h0);
        tick();
        @(negedge CLK);
        chk("t3_ll2_stall_c3", {31'd0, STALL2}, 32'h0);
        chk("t3_ll2_sel_c3", {28'd0, FWD_SEL2}, 32'h5);
        tick();

        // x0 suppression and unused operand
        do_reset();
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
        tick();
        id(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("t4_x0_unused_sel", {28'd0, FWD_SEL}, 32'h0);
        chk("t4_x0_unused_stall", {31'd0, STALL}, 32'h0);
        id(1'b1, 5'd0, 5'd3, 2'b11, 5'd0, 1'b0, 1'b0);
        #1;
        chk("t4_rs2_used_sel", {28'd0, FWD_SEL}, 32'h8);
        id(1'b0, 5'd0, 5'd3, 2'b11, 5'd0, 1'b0, 1'b0);
        #1;
        chk("t4_id_invalid_sel", {28'd0, FWD_SEL}, 32'h0);
        tick();

        // Frozen stall, then FLUSH drops the stalled reader
        do_reset();
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        id(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        PIPE_ADV = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("t5_frozen_stall", {31'd0, STALL}, 32'h1);
            tick();
        end
`ifdef FWD_PERF_CNT_EN
        chk("t5_frozen_cnt", STALL_CNT, 32'h0);
`endif
        PIPE_ADV = 1'b1;
        FLUSH    = 1'b1;
        @(negedge CLK);
        chk("t5_flush_stall", {31'd0, STALL}, 32'h1);
        tick();
        FLUSH = 1'b0;
`ifdef FWD_PERF_CNT_EN
        chk("t5_flush_cnt", STALL_CNT, 32'h0);
`endif
        id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        // EXE bubble, MEM bubble (dropped reader), WB = lw x7
        id(1'b1, 5'd8, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("t5_dropped_sel", {28'd0, FWD_SEL}, 32'h4);
        chk("t5_dropped_stall", {31'd0, STALL}, 32'h0);
        tick();

        // Stall counter, freeze, then reset pulse mid-stall
        do_reset();
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        id(1'b1, 5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
        tick();
`ifdef FWD_PERF_CNT_EN
        chk("t6_cnt_one", STALL_CNT, 32'h1);
`endif
        PIPE_ADV = 1'b0;
        tick();
        tick();
`ifdef FWD_PERF_CNT_EN
        chk("t6_cnt_frozen", STALL_CNT, 32'h1);
`endif
        PIPE_ADV = 1'b1;
        id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
        tick();
        id(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t6_pre_reset_stall", {31'd0, STALL}, 32'h1);
        RESET_N = 1'b0;
        #1;
        chk("t6_async_reset_stall", {31'd0, STALL}, 32'h0);
`ifdef FWD_PERF_CNT_EN
        chk("t6_async_reset_cnt", STALL_CNT, 32'h0);
`endif
        tick();
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("t6_post_reset_stall", {31'd0, STALL}, 32'h0);
        chk("t6_post_reset_sel", {28'd0, FWD_SEL}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
